reg_file_mux_rw: RTL

- Parametrised register file: 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Two registered read ports, each built on the wide select-mux family (generalised from the fixed 32-input, 32-bit selector).
- One synchronous write port, plus a configurable write-to-read bypass.
- Sits between instruction decode and the ALU as the processor's general-purpose register bank.

---
 rtl/reg_file_mux_rw.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_file_mux_rw.sv
// reg_file_mux_rw: general-purpose register bank with two registered read ports
// built on an AND-OR wide select mux, one write port and optional write bypass.
module reg_file_mux_rw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  VALID
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] bank_t;

  bank_t                 mem_q;
  bank_t                 mem_d;
  logic [DATA_WIDTH-1:0] data_r1_q;
  logic [DATA_WIDTH-1:0] data_r1_d;
  logic [DATA_WIDTH-1:0] data_r2_q;
  logic [DATA_WIDTH-1:0] data_r2_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;

  // One-hot AND-OR selector: every word is gated by its own address decode.
  function automatic logic [DATA_WIDTH-1:0] mux_sel(input bank_t words,
                                                    input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      res = res | (words[i] & {DATA_WIDTH{addr == ADDR_WIDTH'(i)}});
    end
    return res;
  endfunction

  // Read-port value: hard zero first, then same-cycle forwarding, then storage.
  function automatic logic [DATA_WIDTH-1:0] read_port(input bank_t                 words,
                                                      input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic                  wr_en,
                                                      input logic [ADDR_WIDTH-1:0] waddr,
                                                      input logic [DATA_WIDTH-1:0] wdata);
    logic [DATA_WIDTH-1:0] res;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      res = '0;
    end else if ((BYPASS != 0) && wr_en && (addr == waddr)) begin
      res = wdata;
    end else begin
      res = mux_sel(words, addr);
    end
    return res;
  endfunction

  // Next-state computation for storage, read registers and VALID.
  always_comb begin
    wr_en_s = WRITE & ~((ZERO_REG != 0) & (ADDR_W == '0));
    mem_d   = mem_q;
    if (wr_en_s) begin
      mem_d[ADDR_W] = DATA_W;
    end else begin
      mem_d = mem_q;
    end

    rd1_s = read_port(mem_q, ADDR_R1, wr_en_s, ADDR_W, DATA_W);
    rd2_s = read_port(mem_q, ADDR_R2, wr_en_s, ADDR_W, DATA_W);

    if (READ) begin
      data_r1_d = rd1_s;
      data_r2_d = rd2_s;
    end else begin
      data_r1_d = data_r1_q;
      data_r2_d = data_r2_q;
    end

    valid_d = READ;
  end

  // State registers; reset wipes storage and outputs without a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q     <= '0;
      data_r1_q <= '0;
      data_r2_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
      valid_q   <= valid_d;
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;
  assign VALID   = valid_q;

endmodule
